// File: rtl/ref_sin_phase_tracker_if.sv
// Signal bundle between the synchrotron phase tracker and its environment:
// arm request, frequency word and booster reference in; phase, error and lock/kick status out.
interface ref_sin_phase_tracker_if;
   logic        readyToOutput;
   logic [31:0] freq;
   logic        phaseBusterRef;
   logic [15:0] phase;
   logic [31:0] phaseErr;
   logic        errValid;
   logic        locked;
   logic        kickerOn;
   logic        refLost;

   modport master (
      output readyToOutput, freq, phaseBusterRef,
      input  phase, phaseErr, errValid, locked, kickerOn, refLost
   );

   modport slave (
      input  readyToOutput, freq, phaseBusterRef,
      output phase, phaseErr, errValid, locked, kickerOn, refLost
   );
endinterface

// File: rtl/ref_sin_phase_tracker.sv
// Synchrotron-side phase tracker: free-running phase accumulator, phase error capture at each
// booster reference edge, lock qualification and a fixed-width kicker pulse once locked.
module ref_sin_phase_tracker #(
   parameter logic [31:0] PHASE_TOL   = 32'h0100_0000,
   parameter int          LOCK_COUNT  = 4,
   parameter int          REF_TIMEOUT = 1048576,
   parameter int          KICK_WIDTH  = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   ref_sin_phase_tracker_if.slave bus
);
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARMED  = 3'd1,
      ST_LOCKED = 3'd2,
      ST_FIRE   = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam logic [3:0]  LOCK_TARGET = 4'(LOCK_COUNT);
   localparam logic [31:0] TIMER_LAST  = 32'(REF_TIMEOUT - 1);
   localparam logic [31:0] KICK_LAST   = 32'(KICK_WIDTH - 1);

   // Unsigned magnitude of a signed phase; the half-turn point maps onto itself.
   function automatic logic [31:0] phase_mag(input logic [31:0] value);
      logic [31:0] result;
      if (value[31]) begin
         result = ~value + 32'd1;
      end else begin
         result = value;
      end
      return result;
   endfunction

   state_t      state_r;
   state_t      state_s;
   logic [31:0] acc_r;
   logic        ref_prev_r;
   logic [31:0] phase_err_r;
   logic        err_valid_r;
   logic        locked_r;
   logic        locked_s;
   logic        kicker_on_r;
   logic        kicker_on_s;
   logic        ref_lost_r;
   logic        ref_lost_s;
   logic [3:0]  match_cnt_r;
   logic [3:0]  match_cnt_s;
   logic [31:0] timer_r;
   logic [31:0] timer_s;
   logic [31:0] kick_cnt_r;
   logic [31:0] kick_cnt_s;

   logic        ref_edge_s;
   logic        in_tol_s;
   logic [3:0]  match_inc_s;
   logic        timeout_s;
   logic        disarm_s;

   // Per-cycle event decode shared by the FSM and the capture path.
   always_comb begin
      ref_edge_s  = bus.phaseBusterRef & ~ref_prev_r;
      in_tol_s    = (phase_mag(acc_r) <= PHASE_TOL);
      match_inc_s = match_cnt_r + 4'd1;
      timeout_s   = ~ref_edge_s & (timer_r == TIMER_LAST);
      disarm_s    = (state_r != ST_IDLE) & ~bus.readyToOutput;
   end

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic; dropping the arm request overrides every other transition.
   always_comb begin
      state_s = state_r;
      if (disarm_s) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.readyToOutput) begin
                  state_s = ST_ARMED;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_ARMED: begin
               if (ref_edge_s && in_tol_s && (match_inc_s == LOCK_TARGET)) begin
                  state_s = ST_LOCKED;
               end else begin
                  state_s = ST_ARMED;
               end
            end
            ST_LOCKED: begin
               if (ref_edge_s) begin
                  state_s = in_tol_s ? ST_FIRE : ST_ARMED;
               end else if (timeout_s) begin
                  state_s = ST_ARMED;
               end else begin
                  state_s = ST_LOCKED;
               end
            end
            ST_FIRE: begin
               if (kick_cnt_r == KICK_LAST) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_FIRE;
               end
            end
            ST_DONE: state_s = ST_DONE;
            default: state_s = ST_IDLE;
         endcase
      end
   end

   // FSM output logic: next values of lock/kick/lost flags and the qualification counters.
   always_comb begin
      locked_s    = locked_r;
      kicker_on_s = kicker_on_r;
      ref_lost_s  = ref_lost_r;
      match_cnt_s = match_cnt_r;
      timer_s     = timer_r;
      kick_cnt_s  = kick_cnt_r;
      if (disarm_s) begin
         locked_s    = 1'b0;
         kicker_on_s = 1'b0;
         match_cnt_s = 4'd0;
         timer_s     = 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               locked_s    = 1'b0;
               kicker_on_s = 1'b0;
               match_cnt_s = 4'd0;
               timer_s     = 32'd0;
               if (bus.readyToOutput) begin
                  ref_lost_s = 1'b0;
               end else begin
                  ref_lost_s = ref_lost_r;
               end
            end
            ST_ARMED: begin
               if (ref_edge_s) begin
                  timer_s = 32'd0;
                  if (in_tol_s) begin
                     match_cnt_s = match_inc_s;
                     locked_s    = (match_inc_s == LOCK_TARGET);
                  end else begin
                     match_cnt_s = 4'd0;
                  end
               end else if (timeout_s) begin
                  ref_lost_s  = 1'b1;
                  locked_s    = 1'b0;
                  match_cnt_s = 4'd0;
                  timer_s     = 32'd0;
               end else begin
                  timer_s = timer_r + 32'd1;
               end
            end
            ST_LOCKED: begin
               if (ref_edge_s) begin
                  timer_s = 32'd0;
                  if (in_tol_s) begin
                     kicker_on_s = 1'b1;
                     kick_cnt_s  = 32'd0;
                  end else begin
                     locked_s    = 1'b0;
                     match_cnt_s = 4'd0;
                  end
               end else if (timeout_s) begin
                  ref_lost_s  = 1'b1;
                  locked_s    = 1'b0;
                  match_cnt_s = 4'd0;
                  timer_s     = 32'd0;
               end else begin
                  timer_s = timer_r + 32'd1;
               end
            end
            ST_FIRE: begin
               if (kick_cnt_r == KICK_LAST) begin
                  kicker_on_s = 1'b0;
               end else begin
                  kick_cnt_s = kick_cnt_r + 32'd1;
               end
            end
            ST_DONE: begin
               locked_s    = 1'b1;
               kicker_on_s = 1'b0;
            end
            default: begin
               locked_s    = 1'b0;
               kicker_on_s = 1'b0;
            end
         endcase
      end
   end

   // Registered status flags and qualification counters.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         locked_r    <= 1'b0;
         kicker_on_r <= 1'b0;
         ref_lost_r  <= 1'b0;
         match_cnt_r <= 4'd0;
         timer_r     <= 32'd0;
         kick_cnt_r  <= 32'd0;
      end else begin
         locked_r    <= locked_s;
         kicker_on_r <= kicker_on_s;
         ref_lost_r  <= ref_lost_s;
         match_cnt_r <= match_cnt_s;
         timer_r     <= timer_s;
         kick_cnt_r  <= kick_cnt_s;
      end
   end

   // Free-running accumulator, reference edge history and phase error capture.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_r       <= 32'd0;
         ref_prev_r  <= 1'b0;
         phase_err_r <= 32'd0;
         err_valid_r <= 1'b0;
      end else begin
         acc_r       <= acc_r + bus.freq;
         ref_prev_r  <= bus.phaseBusterRef;
         err_valid_r <= ref_edge_s & (state_r != ST_IDLE);
         if (ref_edge_s && (state_r != ST_IDLE)) begin
            phase_err_r <= acc_r;
         end else begin
            phase_err_r <= phase_err_r;
         end
      end
   end

   assign bus.phase    = acc_r[31:16];
   assign bus.phaseErr = phase_err_r;
   assign bus.errValid = err_valid_r;
   assign bus.locked   = locked_r;
   assign bus.kickerOn = kicker_on_r;
   assign bus.refLost  = ref_lost_r;
endmodule

// File: tb/tb_ref_sin_phase_tracker.sv
// Directed bench for ref_sin_phase_tracker: phase capture, tolerance boundaries, lock/fire,
// reference timeout, disarm priority, asynchronous reset and accumulator wrap.
module tb_ref_sin_phase_tracker;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   cycle;
   int   checks;
   int   failures;
   int   strobes;
   int   last_edge;
   int   kick_start;

   ref_sin_phase_tracker_if bus_if ();

   ref_sin_phase_tracker #(
      .PHASE_TOL   (32'h0100_0000),
      .LOCK_COUNT  (4),
      .REF_TIMEOUT (1024),
      .KICK_WIDTH  (16)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      cycle++;
   endtask

   task automatic run_to(input int target);
      while (cycle < target) tick();
   endtask

   // Single-cycle reference pulse in cycle 'at'; returns one cycle later with the result visible.
   task automatic pulse_at(input int at);
      run_to(at);
      bus_if.phaseBusterRef = 1'b1;
      tick();
      bus_if.phaseBusterRef = 1'b0;
   endtask

   function automatic int next_slot(input int m);
      int c;
      c = (cycle / 256) * 256 + m;
      while (c <= cycle) c += 256;
      return c;
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      cycle    = 0;
      bus_if.readyToOutput  = 1'b1;
      bus_if.freq           = 32'h0100_0000;
      bus_if.phaseBusterRef = 1'b0;
      #1 reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("rst_phase",    {16'h0, bus_if.phase}, 32'h0);
      check("rst_phaseErr", bus_if.phaseErr,        32'h0);
      check("rst_errValid", {31'h0, bus_if.errValid}, 32'h0);
      check("rst_locked",   {31'h0, bus_if.locked},   32'h0);
      check("rst_kickerOn", {31'h0, bus_if.kickerOn}, 32'h0);
      check("rst_refLost",  {31'h0, bus_if.refLost},  32'h0);
      #4 reset = 1'b0;
      cycle = 0;
      tick();
      check("t1_phase_c1", {16'h0, bus_if.phase}, 32'h0000_0100);

      // Aligned pulses: zero error, lock after the 4th edge, 16-cycle kick after the 5th.
      for (int k = 1; k <= 4; k++) begin
         pulse_at(256 * k);
         check("t1_errValid", {31'h0, bus_if.errValid}, 32'h1);
         check("t1_phaseErr", bus_if.phaseErr, 32'h0);
         check("t1_locked",   {31'h0, bus_if.locked}, (k == 4) ? 32'h1 : 32'h0);
      end
      tick();
      check("t1_strobe_one_cycle", {31'h0, bus_if.errValid}, 32'h0);
      pulse_at(1280);
      kick_start = cycle;
      for (int i = 0; i < 16; i++) begin
         check("t1_kick_high", {31'h0, bus_if.kickerOn}, 32'h1);
         tick();
      end
      check("t1_kick_width", cycle - kick_start, 32'd16);
      check("t1_kick_low",   {31'h0, bus_if.kickerOn}, 32'h0);
      check("t1_done_lock",  {31'h0, bus_if.locked},   32'h1);
      pulse_at(next_slot(0));
      check("t1_done_capture", {31'h0, bus_if.errValid}, 32'h1);
      check("t1_done_nokick",  {31'h0, bus_if.kickerOn}, 32'h0);
      bus_if.readyToOutput = 1'b0;
      tick();
      check("t1_idle_unlock", {31'h0, bus_if.locked}, 32'h0);
      bus_if.readyToOutput = 1'b1;

      // Error just outside tolerance never locks; error equal to tolerance locks and fires.
      for (int k = 0; k < 5; k++) begin
         pulse_at(next_slot(2));
         check("t2_out_phaseErr", bus_if.phaseErr, 32'h0200_0000);
         check("t2_out_locked",   {31'h0, bus_if.locked},   32'h0);
         check("t2_out_kick",     {31'h0, bus_if.kickerOn}, 32'h0);
      end
      for (int k = 1; k <= 5; k++) begin
         pulse_at(next_slot(1));
         check("t2_tol_phaseErr", bus_if.phaseErr, 32'h0100_0000);
         check("t2_tol_locked",   {31'h0, bus_if.locked},   (k >= 4) ? 32'h1 : 32'h0);
         check("t2_tol_kick",     {31'h0, bus_if.kickerOn}, (k == 5) ? 32'h1 : 32'h0);
      end
      bus_if.readyToOutput = 1'b0;
      tick();
      bus_if.readyToOutput = 1'b1;

      // Negative error at -tol locks; a bad edge while locked drops lock and restarts counting.
      for (int k = 1; k <= 4; k++) begin
         pulse_at(next_slot(255));
         check("t3_neg_phaseErr", bus_if.phaseErr, 32'hFF00_0000);
         check("t3_neg_locked",   {31'h0, bus_if.locked}, (k == 4) ? 32'h1 : 32'h0);
      end
      pulse_at(next_slot(3));
      check("t3_bad_phaseErr", bus_if.phaseErr, 32'h0300_0000);
      check("t3_bad_unlock",   {31'h0, bus_if.locked}, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         pulse_at(next_slot(255));
         check("t3_relock", {31'h0, bus_if.locked}, (k == 4) ? 32'h1 : 32'h0);
      end
      last_edge = cycle - 1;

      // Reference timeout after 1024 edge-free cycles; refLost stays set until re-arm from IDLE.
      run_to(last_edge + 1024);
      check("t4_pre_lost",   {31'h0, bus_if.refLost}, 32'h0);
      check("t4_pre_locked", {31'h0, bus_if.locked},  32'h1);
      tick();
      check("t4_lost",       {31'h0, bus_if.refLost}, 32'h1);
      check("t4_lost_unlock", {31'h0, bus_if.locked}, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         pulse_at(next_slot(0));
         check("t4_relock",      {31'h0, bus_if.locked},  (k == 4) ? 32'h1 : 32'h0);
         check("t4_lost_sticky", {31'h0, bus_if.refLost}, 32'h1);
      end
      bus_if.readyToOutput = 1'b0;
      tick();
      check("t4_idle_lost",   {31'h0, bus_if.refLost}, 32'h1);
      check("t4_idle_locked", {31'h0, bus_if.locked},  32'h0);
      bus_if.readyToOutput = 1'b1;
      tick();
      check("t4_rearm_clear", {31'h0, bus_if.refLost}, 32'h0);

      // Disarm on the 5th kicker cycle truncates the pulse; IDLE ignores reference edges.
      for (int k = 1; k <= 5; k++) begin
         pulse_at(next_slot(0));
      end
      check("t5_kick_first", {31'h0, bus_if.kickerOn}, 32'h1);
      run_to(cycle + 4);
      check("t5_kick_fifth", {31'h0, bus_if.kickerOn}, 32'h1);
      bus_if.readyToOutput = 1'b0;
      tick();
      check("t5_kick_cut",   {31'h0, bus_if.kickerOn}, 32'h0);
      check("t5_cut_unlock", {31'h0, bus_if.locked},   32'h0);
      pulse_at(next_slot(128));
      check("t5_idle_nostrobe", {31'h0, bus_if.errValid}, 32'h0);
      check("t5_idle_keep_err", bus_if.phaseErr, 32'h0);
      bus_if.readyToOutput = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         pulse_at(next_slot(0));
      end
      check("t5_locked_before_rst", {31'h0, bus_if.locked}, 32'h1);
      #3 reset = 1'b1;
      #1;
      check("t5_arst_phase",    {16'h0, bus_if.phase}, 32'h0);
      check("t5_arst_phaseErr", bus_if.phaseErr,        32'h0);
      check("t5_arst_locked",   {31'h0, bus_if.locked},   32'h0);
      check("t5_arst_kickerOn", {31'h0, bus_if.kickerOn}, 32'h0);
      check("t5_arst_refLost",  {31'h0, bus_if.refLost},  32'h0);
      bus_if.freq = 32'hFFFF_FFFF;
      #1 reset = 1'b0;
      cycle = 0;

      // Reference held high gives one event; accumulator wraps downward by one per cycle.
      tick();
      check("t6_wrap_c1", {16'h0, bus_if.phase}, 32'h0000_FFFF);
      run_to(2);
      check("t6_wrap_c2", {16'h0, bus_if.phase}, 32'h0000_FFFF);
      bus_if.phaseBusterRef = 1'b1;
      strobes = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (bus_if.errValid) strobes++;
      end
      bus_if.phaseBusterRef = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus_if.errValid) strobes++;
      end
      check("t6_one_strobe",    strobes, 32'd1);
      check("t6_held_phaseErr", bus_if.phaseErr, 32'hFFFF_FFFE);
      pulse_at(60);
      check("t6_wrap_phaseErr", bus_if.phaseErr, 32'hFFFF_FFC4);
      check("t6_wrap_phase",    {16'h0, bus_if.phase}, 32'h0000_FFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ref_sin_phase_tracker.md
Name: ref_sin_phase_tracker

Overview:
Synchrotron-side receiver of the booster 0-phase reference pulse (phaseBusterRef). It runs a local 32-bit phase accumulator at the synchrotron frequency and measures the local phase at every reference edge. It declares lock after consecutive in-tolerance edges, then fires a fixed-width kicker pulse on the next in-tolerance edge. It sits between the booster reference-sine generator and the synchrotron reference-sine/DAC path, and supplies that path with its phase word.

Parameters:
PHASE_TOL, 32'h0100_0000, max allowed |phase error| (unsigned magnitude, 2^32 = one turn)
LOCK_COUNT, 4, consecutive in-tolerance edges needed for lock (1..15)
REF_TIMEOUT, 1048576, cycles without a reference edge before reference is declared lost
KICK_WIDTH, 16, kickerOn high time in cycles (>=1)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
readyToOutput  in  1  arm request; low forces IDLE
freq  in  32  phase increment per clock (synchrotron frequency word)
phaseBusterRef  in  1  booster 0-phase reference, same clock domain; rising edge is the event
phase  out  16  acc[31:16], to synchrotron sine table
phaseErr  out  32  signed local phase captured at last reference edge
errValid  out  1  one-cycle strobe: phaseErr updated
locked  out  1  lock achieved
kickerOn  out  1  kicker fire pulse
refLost  out  1  sticky: reference timeout occurred since arming

Behaviour:
- Reset (async, active-high): acc=0, refPrev=0, phaseErr=0, errValid=0, locked=0, kickerOn=0, refLost=0, matchCnt=0, timer=0, kickCnt=0, state=IDLE.
- The accumulator always runs: acc <= acc + freq, modulo 2^32, in every state. phase = acc[31:16].
- Edge detect: refEdge = phaseBusterRef & ~refPrev, where refPrev is registered. An input held high for many cycles produces exactly one event.
- Capture: in a cycle with refEdge=1, the pre-increment acc value is the error. At the end of that cycle: phaseErr <= acc and errValid <= 1. errValid is 0 in every other cycle. Capture happens in all states except IDLE.
- Magnitude: mag = acc[31] ? (~acc+1) : acc, as a 32-bit unsigned value. 0x8000_0000 gives 0x8000_0000. inTol = (mag <= PHASE_TOL).
- All FSM decisions use refEdge/inTol from the same cycle. Results are visible one clock later, together with errValid.
- FSM:
  IDLE: locked=0, kickerOn=0, matchCnt=0, timer=0. Moves to ARMED when readyToOutput=1, which also clears refLost.
  ARMED: on refEdge, if inTol then matchCnt++, else matchCnt=0. When the incremented matchCnt equals LOCK_COUNT, go to LOCKED and set locked=1.
  LOCKED: on refEdge with inTol, go to FIRE; kickerOn=1 and kickCnt=0 on that same edge. On refEdge with !inTol, go to ARMED with locked=0 and matchCnt=0.
  FIRE: kickerOn stays high for exactly KICK_WIDTH cycles, then goes low and the FSM enters DONE. Reference edges are captured but ignored.
  DONE: locked=1, kickerOn=0. Holds until readyToOutput=0.
- Timeout (ARMED, LOCKED only): timer clears on refEdge and increments otherwise. At timer==REF_TIMEOUT-1 without an edge: refLost=1 (sticky), state ARMED, locked=0, matchCnt=0, timer=0.
- readyToOutput=0 in any non-IDLE state: next cycle state=IDLE, kickerOn=0, locked=0. This has priority over all other transitions, including mid-FIRE, where the pulse is truncated.
- Simultaneous refEdge and timeout expiry: the edge wins, so the timer clears and no timeout occurs.
- freq changes take effect on the next accumulator update. There is no lock reset on a freq change.

Test Plan:
1. freq=0x0100_0000, reset released at cycle 0, readyToOutput=1, single-cycle ref pulses at cycles 256k (k>=1) -> phaseErr=0 each edge; locked rises 1 clk after 4th edge; kickerOn high 16 cycles starting 1 clk after 5th edge; state DONE.
2. Same, pulses at 256k+2 -> phaseErr=0x0200_0000, never locked, kickerOn stays 0. Pulses at 256k+1 -> phaseErr=0x0100_0000 (==tol), locks and fires.
3. Pulses at 256k-1 -> phaseErr=0xFF00_0000 (-tol), inTol, locks. Then one pulse at 256k+3 while LOCKED -> locked drops, matchCnt restarts.
4. REF_TIMEOUT=1024, lock, then stop pulses -> refLost=1 and locked=0 exactly 1024 cycles after last edge; resumed pulses relock after 4 edges, refLost stays 1 until IDLE re-arm.
5. Drop readyToOutput on 5th kicker cycle -> kickerOn=0 next clock, state IDLE; assert reset asynchronously mid-LOCKED -> all outputs 0 immediately, without waiting for a clock edge.
6. phaseBusterRef held high 50 cycles -> exactly one errValid strobe; acc wrap with freq=0xFFFF_FFFF -> phase decrements by 1 LSB of acc per cycle, with no glitch.
